// File: rtl/pmod_hygro_pkg.sv
// Shared constants and clear-handshake state type for the Pmod HYGRO GPIO capture block.
package pmod_hygro_pkg;

  localparam int unsigned PIN_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_ACK  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/pmod_hygro_debounce.sv
// One-bit input conditioner: SYNC_STAGES-deep synchronizer followed, when
// PMOD_HYGRO_DEBOUNCE_EN is defined, by a saturating stability counter.
module pmod_hygro_debounce
  import pmod_hygro_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o
);

  // Elaboration-time parameter range guards
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pmod_hygro_debounce: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("pmod_hygro_debounce: DEBOUNCE_CYCLES must be 1..65535");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef PMOD_HYGRO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  // Count cycles the synchronized input disagrees with the held level
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[SYNC_STAGES-1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`else
  assign level_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pmod_hygro_gpio_capture.sv
// Pmod HYGRO GPIO capture: synchronize/debounce two pins, detect edges, keep sticky
// status with a valid/ready clear and a masked level interrupt. Option: PMOD_HYGRO_DEBOUNCE_EN.
module pmod_hygro_gpio_capture
  import pmod_hygro_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] gpio_top_i,
  output logic [PIN_W-1:0] level_o,
  output logic [PIN_W-1:0] rise_o,
  output logic [PIN_W-1:0] fall_o,
  input  logic [PIN_W-1:0] irq_en_i,
  output logic [PIN_W-1:0] status_o,
  input  logic             clr_valid_i,
  input  logic [PIN_W-1:0] clr_mask_i,
  output logic             clr_ready_o,
  output logic             irq_o
);

  logic [PIN_W-1:0] level;
  logic [PIN_W-1:0] level_dly_q, level_dly_d;
  logic [PIN_W-1:0] rise_q, rise_d;
  logic [PIN_W-1:0] fall_q, fall_d;
  logic [PIN_W-1:0] status_q, status_d;
  logic [PIN_W-1:0] clr_bits;
  logic             irq_q, irq_d;
  logic             clr_ready_q, clr_ready_d;
  clr_state_e       state_q, state_d;

  for (genvar i = 0; i < int'(PIN_W); i++) begin : g_pin
    pmod_hygro_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (gpio_top_i[i]),
      .level_o(level[i])
    );
  end

  // Clear handshake: status is cleared on the edge that raises clr_ready_o
  always_comb begin
    state_d     = state_q;
    clr_ready_d = 1'b0;
    clr_bits    = '0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_valid_i) begin
          state_d     = CLR_ACK;
          clr_ready_d = 1'b1;
          clr_bits    = clr_mask_i;
        end
      end
      CLR_ACK: begin
        state_d = CLR_IDLE;
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  // Edge detect, sticky status (set beats clear) and interrupt
  always_comb begin
    level_dly_d = level;
    rise_d      = level & ~level_dly_q;
    fall_d      = ~level & level_dly_q;
    status_d    = (status_q & ~clr_bits) | rise_q | fall_q;
    irq_d       = |(status_q & irq_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLR_IDLE;
      clr_ready_q <= 1'b0;
      level_dly_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ready_q <= clr_ready_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
    end
  end

  assign level_o     = level;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign status_o    = status_q;
  assign clr_ready_o = clr_ready_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_pmod_hygro_gpio_capture.sv
// Self-checking bench for pmod_hygro_gpio_capture: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the pin-to-status path.
module tb_pmod_hygro_gpio_capture;

  localparam int S  = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gpio_top_i;
  logic [1:0] level_o, rise_o, fall_o, irq_en_i, status_o, clr_mask_i;
  logic       clr_valid_i, clr_ready_o, irq_o;

  int checks = 0;
  int errors = 0;

  pmod_hygro_gpio_capture #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_top_i (gpio_top_i),
    .level_o    (level_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_en_i   (irq_en_i),
    .status_o   (status_o),
    .clr_valid_i(clr_valid_i),
    .clr_mask_i (clr_mask_i),
    .clr_ready_o(clr_ready_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] m_pipe[$];
  logic [1:0] m_sync, m_level, m_prev, m_rise, m_fall, m_status;
  logic       m_ready, m_irq;
  int         m_run[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe = {};
    for (int i = 0; i < S - 1; i++) m_pipe.push_back(2'b00);
    m_sync = '0; m_level = '0; m_prev = '0; m_rise = '0; m_fall = '0;
    m_status = '0; m_ready = 1'b0; m_irq = 1'b0;
    m_run[0] = 0; m_run[1] = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge
  task automatic model_edge(input logic [1:0] pin, input logic [1:0] en,
                            input logic valid, input logic [1:0] mask);
    logic [1:0] new_sync, new_level, clr;
    m_pipe.push_back(pin);
    new_sync = m_pipe[0];
    void'(m_pipe.pop_front());
`ifdef PMOD_HYGRO_DEBOUNCE_EN
    new_level = m_level;
    for (int b = 0; b < 2; b++) begin
      if (m_sync[b] != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          new_level[b] = ~m_level[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
`else
    new_level = new_sync;
`endif
    clr      = (!m_ready && valid) ? mask : 2'b00;
    m_irq    = |(m_status & en);
    m_status = (m_status & ~clr) | m_rise | m_fall;
    m_ready  = !m_ready && valid;
    m_rise   = m_level & ~m_prev;
    m_fall   = ~m_level & m_prev;
    m_prev   = m_level;
    m_level  = new_level;
    m_sync   = new_sync;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"},  32'(level_o),     32'(m_level));
    chk({tag, ".rise"},   32'(rise_o),      32'(m_rise));
    chk({tag, ".fall"},   32'(fall_o),      32'(m_fall));
    chk({tag, ".status"}, 32'(status_o),    32'(m_status));
    chk({tag, ".ready"},  32'(clr_ready_o), 32'(m_ready));
    chk({tag, ".irq"},    32'(irq_o),       32'(m_irq));
  endtask

  task automatic step(input logic [1:0] pin, input logic [1:0] en,
                      input logic valid, input logic [1:0] mask);
    gpio_top_i  = pin;
    irq_en_i    = en;
    clr_valid_i = valid;
    clr_mask_i  = mask;
    @(posedge clk);
    model_edge(pin, en, valid, mask);
    #1;
    check_all("step");
  endtask

  task automatic do_reset(input logic [1:0] pin);
    gpio_top_i  = pin;
    clr_valid_i = 1'b0;
    clr_mask_i  = 2'b00;
    irq_en_i    = 2'b00;
    rst         = 1'b1;
    #1;
    model_reset();
    check_all("reset_now");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int lat;
    logic [1:0] pin;

    // Reset release with bit 0 high: one rise pulse on bit 0
    do_reset(2'b01);
    cnt = 0;
    for (int i = 0; i < 5 + ((DC - 1) * 0); i++) begin
      step(2'b01, 2'b00, 1'b0, 2'b00);
      if (rise_o == 2'b01) cnt++;
    end
`ifndef PMOD_HYGRO_DEBOUNCE_EN
    chk("rst_rise_once", 32'(cnt), 32'd1);
    chk("rst_status", 32'(status_o), 32'(2'b01));
`endif
    for (int i = 0; i < DC + 2; i++) step(2'b01, 2'b00, 1'b0, 2'b00);

    // Build status 11, then clear bit 1 with bit 1 enabled
    for (int i = 0; i < DC + 5; i++) step(2'b11, 2'b10, 1'b0, 2'b00);
    chk("pre_clr_status", 32'(status_o), 32'(2'b11));
    chk("pre_clr_irq", 32'(irq_o), 32'd1);
    step(2'b11, 2'b10, 1'b1, 2'b10);
    chk("clr_ready", 32'(clr_ready_o), 32'd1);
    chk("clr_status", 32'(status_o), 32'(2'b01));
    step(2'b11, 2'b10, 1'b0, 2'b00);
    chk("clr_irq_fall", 32'(irq_o), 32'd0);
    chk("clr_ready_pulse", 32'(clr_ready_o), 32'd0);

    // Fall on bit 0 lands on the same edge as its clear: set wins
    for (int i = 0; i < 2; i++) step(2'b11, 2'b01, 1'b0, 2'b00);
    for (int i = 0; i < 2 + DC * 0; i++) step(2'b10, 2'b01, 1'b0, 2'b00);
`ifdef PMOD_HYGRO_DEBOUNCE_EN
    for (int i = 0; i < DC; i++) step(2'b10, 2'b01, 1'b0, 2'b00);
`endif
    step(2'b10, 2'b01, 1'b0, 2'b00);
    chk("setclr_fall_seen", 32'(fall_o), 32'(2'b01));
    step(2'b10, 2'b01, 1'b1, 2'b01);
    chk("setclr_status0", 32'(status_o[0]), 32'd1);
    step(2'b10, 2'b01, 1'b0, 2'b00);
    chk("setclr_irq", 32'(irq_o), 32'd1);

    // Held clr_valid_i for 6 cycles gives 3 acknowledges
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(2'b10, 2'b00, 1'b1, 2'b11);
      if (clr_ready_o) cnt++;
    end
    chk("held_valid_acks", 32'(cnt), 32'd3);
    step(2'b10, 2'b00, 1'b0, 2'b00);

    // Reset in ACK aborts the handshake
    step(2'b10, 2'b00, 1'b1, 2'b11);
    chk("ack_before_rst", 32'(clr_ready_o), 32'd1);
    do_reset(2'b00);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 2'b00, 1'b0, 2'b00);
      if (clr_ready_o) cnt++;
    end
    chk("no_ack_after_rst", 32'(cnt), 32'd0);

    // Reset mid-count, then measure full latency from release
    for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 1'b0, 2'b00);
    do_reset(2'b10);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(2'b10, 2'b00, 1'b0, 2'b00);
      if (lat == 0 && level_o[1]) lat = i;
    end
`ifdef PMOD_HYGRO_DEBOUNCE_EN
    chk("latency_after_rst", 32'(lat), 32'(S + DC));
`else
    chk("latency_after_rst", 32'(lat), 32'(S));
`endif

`ifdef PMOD_HYGRO_DEBOUNCE_EN
    // Short glitch is filtered; a stable pulse of DC cycles gets through
    do_reset(2'b00);
    for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 1'b0, 2'b00);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 2'b00, 1'b0, 2'b00);
      if (level_o[1]) cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      step(2'b00, 2'b00, 1'b0, 2'b00);
      if (level_o[1]) cnt++;
    end
    chk("glitch_filtered", 32'(cnt), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 2'b00, 1'b0, 2'b00);
      if (rise_o[1]) cnt++;
    end
    chk("stable_rise_once", 32'(cnt), 32'd1);
`endif

    // Random traffic against the model
    do_reset(2'(($urandom)));
    pin = gpio_top_i;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) pin = 2'($urandom);
      step(pin, 2'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
